multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
- Multi-cycle MIPS controller FSM; successor to the single-cycle decoder. Supports addu, subu, jr, lw, sw, lui, ori, beq, jal, plus mult, div, mfhi and mflo.
- Sequences each instruction through IF/ID/EX/MEM/WB, and adds a parametrised mult/div wait state with an internal busy counter.
- Sits between the IR (op/func), the ALU zero flag and the datapath muxes/enables.

Parameters:
- ALUCTRL_W, 3, ALU control width. Codes: 001 or, 010 add, 011 sub, 111 pass/none.
- MULT_CYCLES, 5, cycles spent in S_MD for mult (≥1).
- DIV_CYCLES, 10, cycles spent in S_MD for div (≥1).
- CNT_W, 4, counter width. Must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- op  in  6  IR[31:26]. Stable from S_ID until the next S_IF.
- func  in  6  IR[5:0].
- zero  in  1  ALU equality flag, valid in S_EX.
- PCWrite  out  1  PC load enable.
- IRWrite  out  1  IR load enable.
- NPCSel  out  2  next PC select: 00 PC+4, 01 branch target, 10 jump target (instr_index), 11 rs.
- RegWrite  out  1  GRF write enable.
- RegDst  out  2  write-register select: 00 rt, 01 rd, 10 $31.
- ALUSrc  out  1  ALU B select: 0 rt, 1 extended immediate.
- ExtOp  out  1  immediate extension: 1 zero-extend, 0 sign-extend.
- ALUCtrl  out  ALUCTRL_W  ALU operation code.
- MemWrite  out  1  DM write enable.
- MemtoReg  out  3  GRF write-data select: 000 ALU, 001 imm<<16, 010 DM, 011 PC+4, 100 HI, 101 LO.
- MDStart  out  1  one-cycle start pulse to the mult/div unit.
- MDOp  out  1  mult/div operation: 0 mult, 1 div. Valid with MDStart.
- MDBusy  out  1  high while in S_MD.
- state  out  3  current state, for debug.

Behaviour:
- State encoding: S_IF=0, S_ID=1, S_EX=2, S_MEM=3, S_WB=4, S_MD=5.
- Registers: state and cnt[CNT_W-1:0] only. All outputs decode combinationally from state, op, func and zero.
- Reset (asynchronous, any state, including mid-S_MD): state←S_IF, cnt←0.
- While reset is high, every output is forced to 0, except state, which reads 0 (S_IF).
- Default output values in any state: all enables 0, NPCSel 00, RegDst 00, ALUSrc 0, ExtOp 0, ALUCtrl 111, MemtoReg 000.
- S_IF: IRWrite=1, PCWrite=1, NPCSel=00. Next state S_ID.
- S_ID, jal: PCWrite=1, NPCSel=10, RegWrite=1, RegDst=10, MemtoReg=011. Next state S_IF.
- S_ID, jr (op 0, func 001000): PCWrite=1, NPCSel=11. Next state S_IF. No register write.
- S_ID, unrecognised op/func: treated as nop, next state S_IF, no enables asserted.
- S_ID, any other recognised instruction: next state S_EX.
- S_EX, addu: ALUCtrl=010 → S_WB. subu: ALUCtrl=011 → S_WB.
- S_EX, ori: ALUSrc=1, ExtOp=1, ALUCtrl=001 → S_WB.
- S_EX, lui: ALUCtrl=111 → S_WB.
- S_EX, lw/sw: ALUSrc=1, ExtOp=0, ALUCtrl=010 → S_MEM.
- S_EX, beq: ALUCtrl=011. If zero=1 then PCWrite=1 and NPCSel=01; zero=0 means no PC write. Next state S_IF in both cases.
- S_EX, mfhi/mflo: no enables → S_WB.
- S_EX, mult/div: MDStart=1 and MDOp per instruction; cnt←MULT_CYCLES or DIV_CYCLES. Next state S_MD.
- S_MD: MDBusy=1, cnt decrements by 1 each cycle. While cnt==1 the FSM moves to S_IF and cnt←0. Residency is therefore exactly MULT_CYCLES or DIV_CYCLES cycles. No GRF, DM or PC writes occur in S_MD.
- S_MEM, sw: MemWrite=1, ALUSrc=1, ALUCtrl=010, all held for address stability. Next state S_IF.
- S_MEM, lw: same ALU controls as sw, no write. Next state S_WB.
- S_WB: RegWrite=1. Next state S_IF. Per instruction:
  - addu/subu: RegDst=01, MemtoReg=000.
  - ori: RegDst=00, MemtoReg=000.
  - lui: RegDst=00, MemtoReg=001.
  - lw: RegDst=00, MemtoReg=010.
  - mfhi: RegDst=01, MemtoReg=100.
  - mflo: RegDst=01, MemtoReg=101.
- CPI by instruction:
  - jal, jr: 2.
  - nop/unknown: 2.
  - beq: 3.
  - sw: 4.
  - R-type ALU ops, ori, lui, mfhi, mflo: 4.
  - lw: 5.
  - mult: 3+MULT_CYCLES. div: 3+DIV_CYCLES.
- An illegal state value (6 or 7) returns to S_IF on the next clock, with no enables asserted.

Test Plan:
- Reset pulse during S_MEM of sw → MemWrite=0 immediately (asynchronously). After release: state=0, IRWrite=1, PCWrite=1.
- addu (op 000000, func 100001) → states 0,1,2,4,0. In S_WB: RegWrite=1, RegDst=01, MemtoReg=000, and 4 cycles total.
- lw (op 100011) → states 0,1,2,3,4. MemWrite stays 0 throughout; S_WB shows MemtoReg=010, RegDst=00.
- beq with zero=1, then beq with zero=0 → first: PCWrite=1, NPCSel=01 in S_EX. Second: PCWrite=0 in S_EX. Both return to S_IF after 3 cycles.
- jal → in S_ID: RegWrite=1, RegDst=10, MemtoReg=011, NPCSel=10, PCWrite=1; next state S_IF.
- div with defaults (DIV_CYCLES=10) → MDStart for 1 cycle with MDOp=1, then MDBusy high for exactly 10 cycles, then S_IF. A reset asserted at MD cycle 4 returns the FSM to S_IF with cnt=0.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS controller: sequences IF/ID/EX/MEM/WB plus a counted mult/div wait state.
// Datapath controls decode combinationally from state, op, func and zero.
module multi_cycle_ctrl #(
  parameter int unsigned ALUCTRL_W   = 3,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           func,
  input  logic                 zero,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic [1:0]           NPCSel,
  output logic                 RegWrite,
  output logic [1:0]           RegDst,
  output logic                 ALUSrc,
  output logic                 ExtOp,
  output logic [ALUCTRL_W-1:0] ALUCtrl,
  output logic                 MemWrite,
  output logic [2:0]           MemtoReg,
  output logic                 MDStart,
  output logic                 MDOp,
  output logic                 MDBusy,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_MD = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    I_NOP, I_ADDU, I_SUBU, I_JR, I_LW, I_SW, I_LUI, I_ORI,
    I_BEQ, I_JAL, I_MULT, I_DIV, I_MFHI, I_MFLO
  } instr_t;

  state_t           cur;
  logic [CNT_W-1:0] cnt;
  instr_t           instr;

  // Instruction decode from the IR fields
  always_comb begin
    instr = I_NOP;
    case (op)
      6'b000000: begin
        case (func)
          6'b100001: instr = I_ADDU;
          6'b100011: instr = I_SUBU;
          6'b001000: instr = I_JR;
          6'b011000: instr = I_MULT;
          6'b011010: instr = I_DIV;
          6'b010000: instr = I_MFHI;
          6'b010010: instr = I_MFLO;
          default:   instr = I_NOP;
        endcase
      end
      6'b100011: instr = I_LW;
      6'b101011: instr = I_SW;
      6'b001111: instr = I_LUI;
      6'b001101: instr = I_ORI;
      6'b000100: instr = I_BEQ;
      6'b000011: instr = I_JAL;
      default:   instr = I_NOP;
    endcase
  end

  // State and mult/div residency counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= S_IF;
      cnt <= '0;
    end else begin
      case (cur)
        S_IF: cur <= S_ID;
        S_ID: begin
          case (instr)
            I_JAL, I_JR, I_NOP: cur <= S_IF;
            default:            cur <= S_EX;
          endcase
        end
        S_EX: begin
          case (instr)
            I_ADDU, I_SUBU, I_ORI, I_LUI, I_MFHI, I_MFLO: cur <= S_WB;
            I_LW, I_SW: cur <= S_MEM;
            I_MULT: begin
              cnt <= CNT_W'(MULT_CYCLES);
              cur <= S_MD;
            end
            I_DIV: begin
              cnt <= CNT_W'(DIV_CYCLES);
              cur <= S_MD;
            end
            default: cur <= S_IF;
          endcase
        end
        S_MEM: cur <= (instr == I_LW) ? S_WB : S_IF;
        S_WB:  cur <= S_IF;
        S_MD: begin
          // cnt==0 cannot occur here, but exiting on it avoids a 2^CNT_W stall
          if (cnt <= CNT_W'(1)) begin
            cnt <= '0;
            cur <= S_IF;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: cur <= S_IF;
      endcase
    end
  end

  assign state = cur;

  // Control decode; everything held at zero while reset is asserted
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    NPCSel   = 2'b00;
    RegWrite = 1'b0;
    RegDst   = 2'b00;
    ALUSrc   = 1'b0;
    ExtOp    = 1'b0;
    ALUCtrl  = ALUCTRL_W'(3'b111);
    MemWrite = 1'b0;
    MemtoReg = 3'b000;
    MDStart  = 1'b0;
    MDOp     = 1'b0;
    MDBusy   = 1'b0;
    if (reset) begin
      ALUCtrl = '0;
    end else begin
      case (cur)
        S_IF: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        S_ID: begin
          if (instr == I_JAL) begin
            PCWrite  = 1'b1;
            NPCSel   = 2'b10;
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 3'b011;
          end else if (instr == I_JR) begin
            PCWrite = 1'b1;
            NPCSel  = 2'b11;
          end
        end
        S_EX: begin
          case (instr)
            I_ADDU: ALUCtrl = ALUCTRL_W'(3'b010);
            I_SUBU: ALUCtrl = ALUCTRL_W'(3'b011);
            I_ORI: begin
              ALUSrc  = 1'b1;
              ExtOp   = 1'b1;
              ALUCtrl = ALUCTRL_W'(3'b001);
            end
            I_LW, I_SW: begin
              ALUSrc  = 1'b1;
              ALUCtrl = ALUCTRL_W'(3'b010);
            end
            I_BEQ: begin
              ALUCtrl = ALUCTRL_W'(3'b011);
              if (zero) begin
                PCWrite = 1'b1;
                NPCSel  = 2'b01;
              end
            end
            I_MULT: MDStart = 1'b1;
            I_DIV: begin
              MDStart = 1'b1;
              MDOp    = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          ALUSrc   = 1'b1;
          ALUCtrl  = ALUCTRL_W'(3'b010);
          MemWrite = (instr == I_SW);
        end
        S_WB: begin
          RegWrite = 1'b1;
          case (instr)
            I_ADDU, I_SUBU: RegDst = 2'b01;
            I_LUI:          MemtoReg = 3'b001;
            I_LW:           MemtoReg = 3'b010;
            I_MFHI: begin
              RegDst   = 2'b01;
              MemtoReg = 3'b100;
            end
            I_MFLO: begin
              RegDst   = 2'b01;
              MemtoReg = 3'b101;
            end
            default: ;
          endcase
        end
        S_MD: MDBusy = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: directed and random instruction streams against a
// per-instruction control-trace model.
module tb_multi_cycle_ctrl;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  typedef enum int {
    C_ADDU, C_SUBU, C_JR, C_LW, C_SW, C_LUI, C_ORI,
    C_BEQ, C_JAL, C_MULT, C_DIV, C_MFHI, C_MFLO, C_NOP
  } cls_t;

  typedef struct packed {
    logic [9:0] pad;
    logic       pcw;
    logic       irw;
    logic [1:0] npc;
    logic       rw;
    logic [1:0] rd;
    logic       als;
    logic       ext;
    logic [2:0] alu;
    logic       mw;
    logic [2:0] m2r;
    logic       mds;
    logic       mdop;
    logic       busy;
    logic [2:0] st;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, func;
  logic       zero;
  logic       PCWrite, IRWrite, RegWrite, ALUSrc, ExtOp, MemWrite;
  logic       MDStart, MDOp, MDBusy;
  logic [1:0] NPCSel, RegDst;
  logic [2:0] ALUCtrl, MemtoReg, state;

  ctrl_t obs;
  ctrl_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  multi_cycle_ctrl #(
    .ALUCTRL_W(3), .MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .NPCSel(NPCSel), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .ExtOp(ExtOp), .ALUCtrl(ALUCtrl),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .MDStart(MDStart), .MDOp(MDOp),
    .MDBusy(MDBusy), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {10'b0, PCWrite, IRWrite, NPCSel, RegWrite, RegDst, ALUSrc, ExtOp,
                ALUCtrl, MemWrite, MemtoReg, MDStart, MDOp, MDBusy, state};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ctrl_t idle(input int st);
    ctrl_t v;
    v     = '0;
    v.alu = 3'b111;
    v.st  = 3'(st);
    return v;
  endfunction

  // Expected cycle-by-cycle controls for one instruction, from its architectural steps
  function automatic void build(input cls_t c, input logic z);
    ctrl_t v;
    exp_q.delete();
    v = idle(0); v.pcw = 1'b1; v.irw = 1'b1;
    exp_q.push_back(v);
    v = idle(1);
    if (c == C_JAL) begin
      v.pcw = 1'b1; v.npc = 2'b10; v.rw = 1'b1; v.rd = 2'b10; v.m2r = 3'b011;
    end else if (c == C_JR) begin
      v.pcw = 1'b1; v.npc = 2'b11;
    end
    exp_q.push_back(v);
    if (c == C_JAL || c == C_JR || c == C_NOP) return;
    v = idle(2);
    case (c)
      C_ADDU: v.alu = 3'b010;
      C_SUBU: v.alu = 3'b011;
      C_ORI:  begin v.als = 1'b1; v.ext = 1'b1; v.alu = 3'b001; end
      C_LW, C_SW: begin v.als = 1'b1; v.alu = 3'b010; end
      C_BEQ:  begin v.alu = 3'b011; v.pcw = z; v.npc = z ? 2'b01 : 2'b00; end
      C_MULT: v.mds = 1'b1;
      C_DIV:  begin v.mds = 1'b1; v.mdop = 1'b1; end
      default: ;
    endcase
    exp_q.push_back(v);
    if (c == C_MULT || c == C_DIV) begin
      for (int k = 0; k < int'((c == C_MULT) ? MULT_N : DIV_N); k++) begin
        v = idle(5); v.busy = 1'b1;
        exp_q.push_back(v);
      end
      return;
    end
    if (c == C_BEQ) return;
    if (c == C_LW || c == C_SW) begin
      v = idle(3); v.als = 1'b1; v.alu = 3'b010; v.mw = (c == C_SW);
      exp_q.push_back(v);
      if (c == C_SW) return;
    end
    v = idle(4); v.rw = 1'b1;
    case (c)
      C_ADDU, C_SUBU: v.rd = 2'b01;
      C_LUI:  v.m2r = 3'b001;
      C_LW:   v.m2r = 3'b010;
      C_MFHI: begin v.rd = 2'b01; v.m2r = 3'b100; end
      C_MFLO: begin v.rd = 2'b01; v.m2r = 3'b101; end
      default: ;
    endcase
    exp_q.push_back(v);
  endfunction

  function automatic void encode(input cls_t c, output logic [5:0] o, output logic [5:0] f);
    logic [5:0] bad_op [4]   = '{6'h01, 6'h02, 6'h20, 6'h3f};
    logic [5:0] bad_func [4] = '{6'h00, 6'h02, 6'h20, 6'h2a};
    o = 6'h00;
    f = 6'($urandom);
    case (c)
      C_ADDU: f = 6'b100001;
      C_SUBU: f = 6'b100011;
      C_JR:   f = 6'b001000;
      C_MULT: f = 6'b011000;
      C_DIV:  f = 6'b011010;
      C_MFHI: f = 6'b010000;
      C_MFLO: f = 6'b010010;
      C_LW:   o = 6'b100011;
      C_SW:   o = 6'b101011;
      C_LUI:  o = 6'b001111;
      C_ORI:  o = 6'b001101;
      C_BEQ:  o = 6'b000100;
      C_JAL:  o = 6'b000011;
      default: begin
        if ($urandom_range(0, 1) == 1) o = bad_op[$urandom_range(0, 3)];
        else f = bad_func[$urandom_range(0, 3)];
      end
    endcase
  endfunction

  // Runs one instruction from S_IF; stop>=0 asserts reset right after that cycle's check
  task automatic run_instr(input cls_t c, input logic z, input int stop);
    logic [5:0] o, f;
    build(c, z);
    encode(c, o, f);
    op = o; func = f; zero = z;
    foreach (exp_q[i]) begin
      if (i > 0) @(negedge clk);
      #1;
      check($sformatf("%s_z%0d_c%0d", c.name(), z, i), obs, exp_q[i]);
      if (i == stop) begin
        reset = 1'b1;
        #1;
        check($sformatf("%s_rst_async", c.name()), obs, 32'h0);
        @(negedge clk);
        #1;
        check($sformatf("%s_rst_hold", c.name()), obs, 32'h0);
        reset = 1'b0;
        return;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    op = 6'h00; func = 6'h00; zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_state", obs, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run_instr(C_SW, 1'b0, 3);
    run_instr(C_ADDU, 1'b0, -1);
    run_instr(C_LW, 1'b1, -1);
    run_instr(C_BEQ, 1'b1, -1);
    run_instr(C_BEQ, 1'b0, -1);
    run_instr(C_JAL, 1'b0, -1);
    run_instr(C_DIV, 1'b0, -1);
    run_instr(C_DIV, 1'b1, 6);
    run_instr(C_MULT, 1'b0, -1);
    run_instr(C_NOP, 1'b0, -1);

    for (int n = 0; n < 80; n++)
      run_instr(cls_t'($urandom_range(0, 13)), 1'($urandom), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
